// File: rtl/id_pkg.sv
// id_pkg: opcode/funct constants, control-bundle bit offsets and enums shared by the MIPS decode stage.
package id_pkg;
   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
   localparam logic [5:0] OP_COP0 = 6'h10, OP_BEQL = 6'h14, OP_BNEL = 6'h15, OP_BLEZL = 6'h16, OP_BGTZL = 6'h17;
   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09, FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D, FN_ERET = 6'h18;
   localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
   localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
   localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_CO = 5'h10;
   localparam int C_MEM2REG = 0, C_REGWRITE = 1, C_MEMWRITE = 2, C_ALUSRC = 3, C_SHIFTI = 4, C_ALU = 5;
   localparam int C_RI = 13, C_SYSCALL = 14, C_BREAK = 15, C_ERET = 16, C_MFC0 = 17, C_MTC0 = 18, C_LINK = 19;
   typedef enum logic [3:0] {BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ, BR_J, BR_JR} br_kind_e;
   typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_kind_e;
   typedef enum logic [1:0] {RUN, SLOT, SQUASH} state_e;
   // I-type ALU ops reuse the R-type funct encoding; LUI ORs the shifted immediate with $0
   function automatic logic [5:0] alu_imm(input logic [5:0] op);
      return op == OP_ADDI ? FN_ADD : op == OP_ADDIU ? FN_ADDU : op == OP_SLTI ? FN_SLT :
             op == OP_SLTIU ? FN_SLTU : op == OP_ANDI ? FN_AND : op == OP_XORI ? FN_XOR : FN_OR;
   endfunction
endpackage

// File: rtl/id_decoder.sv
// id_decoder: instruction word -> control bundle, branch kind, immediate kind and remapped rd/rt.
// Branch-likely opcodes decode only when ID_BRANCH_LIKELY_EN is defined; otherwise they raise RI.
module id_decoder import id_pkg::*; #(
   parameter int CTRL_W = 24
) (
   input  logic [31:0]       instr,
   output logic [CTRL_W-1:0] ctrl,
   output logic [3:0]        br_kind,
   output logic              likely,
   output logic [1:0]        imm_kind,
   output logic [4:0]        rd,
   output logic [4:0]        rt
);
   logic [5:0] op, fn;
   assign op = instr[31:26];
   assign fn = instr[5:0];
   always_comb begin
      ctrl = '0;
      br_kind = BR_NONE;
      likely = 1'b0;
      imm_kind = IMM_SEXT;
      rd = instr[15:11];
      rt = instr[20:16];
      case (op)
         OP_SPECIAL: case (fn)
            FN_SLL, FN_SRL, FN_SRA: begin ctrl[C_REGWRITE] = 1'b1; ctrl[C_SHIFTI] = 1'b1; ctrl[C_ALU +: 8] = {2'b0, fn}; end
            FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
               begin ctrl[C_REGWRITE] = 1'b1; ctrl[C_ALU +: 8] = {2'b0, fn}; end
            FN_JR: br_kind = BR_JR;
            FN_JALR: begin br_kind = BR_JR; ctrl[C_REGWRITE] = 1'b1; ctrl[C_LINK] = 1'b1; end
            FN_SYSCALL: ctrl[C_SYSCALL] = 1'b1;
            FN_BREAK: ctrl[C_BREAK] = 1'b1;
            default: ctrl[C_RI] = 1'b1;
         endcase
         OP_REGIMM: case (instr[20:16])
            RT_BLTZ: br_kind = BR_LTZ;
            RT_BGEZ: br_kind = BR_GEZ;
            RT_BLTZAL: begin br_kind = BR_LTZ; ctrl[C_REGWRITE] = 1'b1; ctrl[C_LINK] = 1'b1; rd = 5'd31; end
            RT_BGEZAL: begin br_kind = BR_GEZ; ctrl[C_REGWRITE] = 1'b1; ctrl[C_LINK] = 1'b1; rd = 5'd31; end
            default: ctrl[C_RI] = 1'b1;
         endcase
         OP_J: br_kind = BR_J;
         OP_JAL: begin br_kind = BR_J; ctrl[C_REGWRITE] = 1'b1; ctrl[C_LINK] = 1'b1; rd = 5'd31; end
         OP_BEQ: br_kind = BR_EQ;
         OP_BNE: br_kind = BR_NE;
         OP_BLEZ: br_kind = BR_LEZ;
         OP_BGTZ: br_kind = BR_GTZ;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ctrl[C_REGWRITE] = 1'b1;
            ctrl[C_ALUSRC] = 1'b1;
            ctrl[C_ALU +: 8] = {2'b0, alu_imm(op)};
            imm_kind = op == OP_LUI ? IMM_LUI : (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? IMM_ZEXT : IMM_SEXT;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            ctrl[C_REGWRITE] = 1'b1; ctrl[C_MEM2REG] = 1'b1; ctrl[C_ALUSRC] = 1'b1; ctrl[C_ALU +: 8] = {2'b0, FN_ADDU};
         end
         OP_SB, OP_SH, OP_SW: begin
            ctrl[C_MEMWRITE] = 1'b1; ctrl[C_ALUSRC] = 1'b1; ctrl[C_ALU +: 8] = {2'b0, FN_ADDU};
         end
         OP_COP0: begin
            if (instr[25:21] == RS_MFC0) begin
               ctrl[C_MFC0] = 1'b1; ctrl[C_REGWRITE] = 1'b1; rd = instr[20:16]; rt = instr[15:11];
            end else if (instr[25:21] == RS_MTC0) ctrl[C_MTC0] = 1'b1;
            else if (instr[25:21] == RS_CO && fn == FN_ERET) ctrl[C_ERET] = 1'b1;
            else ctrl[C_RI] = 1'b1;
         end
`ifdef ID_BRANCH_LIKELY_EN
         OP_BEQL: begin br_kind = BR_EQ; likely = 1'b1; end
         OP_BNEL: begin br_kind = BR_NE; likely = 1'b1; end
         OP_BLEZL: begin br_kind = BR_LEZ; likely = 1'b1; end
         OP_BGTZL: begin br_kind = BR_GTZ; likely = 1'b1; end
`endif
         default: ctrl[C_RI] = 1'b1;
      endcase
      if (instr == '0) ctrl = '0;
   end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage with register file, operand forwarding, ID branch resolution,
// registered ID/EX boundary and delay-slot/squash FSM. ID_BRANCH_LIKELY_EN enables branch-likely annulment.
module id_stage_pipe import id_pkg::*; #(
   parameter int NUM_FWD = 2,
   parameter int FSEL_W = $clog2(NUM_FWD + 1),
   parameter int CTRL_W = 24,
   parameter int RF_BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [31:0]           in_pc,
   input  logic                  wb_we,
   input  logic [4:0]            wb_addr,
   input  logic [31:0]           wb_data,
   input  logic [NUM_FWD*32-1:0] fwd_data,
   input  logic [FSEL_W-1:0]     fwd_sel_rs,
   input  logic [FSEL_W-1:0]     fwd_sel_rt,
   input  logic                  hazard_stall,
   input  logic                  ex_flush,
   output logic                  br_taken,
   output logic [31:0]           br_target,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_W-1:0]     out_ctrl,
   output logic [31:0]           out_rs_data,
   output logic [31:0]           out_rt_data,
   output logic [31:0]           out_imm,
   output logic [31:0]           out_link,
   output logic [4:0]            out_rs,
   output logic [4:0]            out_rt,
   output logic [4:0]            out_rd,
   output logic [4:0]            out_shamt,
   output logic [31:0]           out_pc
);
   logic [31:0] rf [32];
   logic [CTRL_W-1:0] ctrl;
   logic [3:0] br_kind;
   logic [1:0] imm_kind;
   logic [4:0] rs, rt_f, rd, dec_rt;
   logic [31:0] rf_rs, rf_rt, rs_val, rt_val, imm, pc4, tgt_q;
   logic likely, cond, acc, eval, issue, squash_drop, annul_set, annul_q, annul_d;
   state_e state_q, state_d;
   id_decoder #(.CTRL_W(CTRL_W)) u_dec (
      .instr(in_instr), .ctrl(ctrl), .br_kind(br_kind), .likely(likely),
      .imm_kind(imm_kind), .rd(rd), .rt(dec_rt)
   );
   assign rs = in_instr[25:21];
   assign rt_f = in_instr[20:16];
   assign rf_rs = (RF_BYPASS != 0 && wb_we && wb_addr == rs && rs != '0) ? wb_data : rf[rs];
   assign rf_rt = (RF_BYPASS != 0 && wb_we && wb_addr == rt_f && rt_f != '0) ? wb_data : rf[rt_f];
   always_ff @(posedge clk)
      if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
      else if (wb_we && wb_addr != '0) rf[wb_addr] <= wb_data;
   always_comb begin
      rs_val = rf_rs;
      rt_val = rf_rt;
      for (int k = 1; k <= NUM_FWD; k++) begin
         if (fwd_sel_rs == FSEL_W'(k)) rs_val = fwd_data[32*k-32 +: 32];
         if (fwd_sel_rt == FSEL_W'(k)) rt_val = fwd_data[32*k-32 +: 32];
      end
   end
   assign imm = imm_kind == IMM_ZEXT ? {16'b0, in_instr[15:0]} :
                imm_kind == IMM_LUI ? {in_instr[15:0], 16'b0} : {{16{in_instr[15]}}, in_instr[15:0]};
   assign pc4 = in_pc + 32'd4;
   assign cond = (br_kind == BR_EQ && rs_val == rt_val) || (br_kind == BR_NE && rs_val != rt_val) ||
                 (br_kind == BR_LEZ && (rs_val[31] || rs_val == '0)) || (br_kind == BR_GTZ && !rs_val[31] && rs_val != '0) ||
                 (br_kind == BR_LTZ && rs_val[31]) || (br_kind == BR_GEZ && !rs_val[31]) ||
                 br_kind == BR_J || br_kind == BR_JR;
   assign br_target = br_kind == BR_J ? {pc4[31:28], in_instr[25:0], 2'b00} :
                      br_kind == BR_JR ? rs_val : pc4 + {imm[29:0], 2'b00};
   assign in_ready = ex_flush || (!hazard_stall && (!out_valid || out_ready));
   assign acc = in_valid && in_ready;
   assign squash_drop = state_q == SQUASH && in_pc != tgt_q;
   // a branch sitting in the delay slot is never evaluated
   assign eval = acc && !rst && !ex_flush && state_q != SLOT && !squash_drop;
   assign br_taken = eval && cond;
   assign annul_set = eval && likely && !cond;
   assign issue = acc && !ex_flush && !squash_drop && !(state_q == SLOT && annul_q);
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= RUN;
         annul_q <= 1'b0;
         tgt_q <= '0;
      end else begin
         state_q <= state_d;
         annul_q <= annul_d;
         if (br_taken) tgt_q <= br_target;
      end
   always_comb begin
      state_d = state_q;
      annul_d = annul_q;
      if (ex_flush) begin
         state_d = RUN;
         annul_d = 1'b0;
      end else if (acc && state_q == SLOT) begin
         state_d = annul_q ? RUN : SQUASH;
         annul_d = 1'b0;
      end else if (acc && !squash_drop) begin
         state_d = (br_taken || annul_set) ? SLOT : RUN;
         annul_d = annul_set;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         out_valid <= 1'b0;
         out_ctrl <= '0;
         out_rs_data <= '0;
         out_rt_data <= '0;
         out_imm <= '0;
         out_link <= '0;
         out_rs <= '0;
         out_rt <= '0;
         out_rd <= '0;
         out_shamt <= '0;
         out_pc <= '0;
      end else if (ex_flush) out_valid <= 1'b0;
      else if (issue) begin
         out_valid <= 1'b1;
         out_ctrl <= ctrl;
         out_rs_data <= rs_val;
         out_rt_data <= rt_val;
         out_imm <= imm;
         out_link <= in_pc + 32'd8;
         out_rs <= rs;
         out_rt <= dec_rt;
         out_rd <= rd;
         out_shamt <= in_instr[10:6];
         out_pc <= in_pc;
      end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed self-checking bench for id_stage_pipe with hand-computed expectations.
module tb_id_stage_pipe;
   logic clk = 1'b0, rst, in_valid, in_ready, wb_we, hazard_stall, ex_flush, br_taken, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, wb_data, br_target, out_rs_data, out_rt_data, out_imm, out_link, out_pc;
   logic [4:0] wb_addr, out_rs, out_rt, out_rd, out_shamt;
   logic [63:0] fwd_data;
   logic [1:0] fwd_sel_rs, fwd_sel_rt;
   logic [23:0] out_ctrl;
   int checks = 0, failures = 0;
   localparam logic [31:0] ADDU_A = 32'h00A0_1821;
   always #5 clk = ~clk;
   id_stage_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .fwd_data(fwd_data), .fwd_sel_rs(fwd_sel_rs),
      .fwd_sel_rt(fwd_sel_rt), .hazard_stall(hazard_stall), .ex_flush(ex_flush), .br_taken(br_taken),
      .br_target(br_target), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm), .out_link(out_link),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .out_pc(out_pc)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      in_valid = v;
      in_instr = instr;
      in_pc = pc;
   endtask
   initial begin
      rst = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0; fwd_data = '0; fwd_sel_rs = '0; fwd_sel_rt = '0;
      hazard_stall = 1'b0; ex_flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, '0, '0);
      tick;
      tick;
      chk("rst_valid", {31'b0, out_valid}, 0);
      chk("rst_ctrl", {8'b0, out_ctrl}, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_link", out_link, 0);
      chk("rst_br", {31'b0, br_taken}, 0);
      rst = 1'b0;
      // WB write-through on the same cycle as the read
      drive(1'b1, ADDU_A, 32'h40);
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
      #1 chk("byp_ready", {31'b0, in_ready}, 1);
      tick;
      wb_we = 1'b0;
      chk("byp_valid", {31'b0, out_valid}, 1);
      chk("byp_rs", out_rs_data, 32'h1234);
      chk("byp_rd", {27'b0, out_rd}, 3);
      chk("byp_ctrl", {8'b0, out_ctrl}, 32'h422);
      chk("byp_pc", out_pc, 32'h40);
      drive(1'b0, '0, '0);
      wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h7;
      tick;
      // $0 write is ignored even with bypass
      drive(1'b1, 32'h0005_1821, 32'h44);
      wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      tick;
      wb_we = 1'b0;
      chk("r0_rs", out_rs_data, 0);
      chk("rf_rt", out_rt_data, 32'h1234);
      // BEQ with forwarded rs, delay slot, squash, target
      drive(1'b1, 32'h1022_0004, 32'h100);
      fwd_sel_rs = 2'd1; fwd_data = 64'h7;
      #1 chk("beq_taken", {31'b0, br_taken}, 1);
      chk("beq_tgt", br_target, 32'h114);
      tick;
      fwd_sel_rs = '0;
      chk("beq_valid", {31'b0, out_valid}, 1);
      chk("beq_pc", out_pc, 32'h100);
      chk("beq_rs", out_rs_data, 7);
      chk("beq_imm", out_imm, 4);
      drive(1'b1, 32'h1000_0008, 32'h104);
      #1 chk("slot_br", {31'b0, br_taken}, 0);
      tick;
      chk("slot_valid", {31'b0, out_valid}, 1);
      chk("slot_pc", out_pc, 32'h104);
      drive(1'b1, ADDU_A, 32'h108);
      #1 chk("sq_ready", {31'b0, in_ready}, 1);
      tick;
      chk("sq_drop", {31'b0, out_valid}, 0);
      drive(1'b1, ADDU_A, 32'h114);
      tick;
      chk("tgt_valid", {31'b0, out_valid}, 1);
      chk("tgt_pc", out_pc, 32'h114);
      drive(1'b1, 32'h1000_0001, 32'h118);
      #1 chk("run_br", {31'b0, br_taken}, 1);
      chk("run_tgt", br_target, 32'h120);
      in_valid = 1'b0;
      tick;
      // hazard stall: two bubbles, single issue
      drive(1'b1, ADDU_A, 32'h1FC);
      tick;
      chk("hz_pre", out_pc, 32'h1FC);
      drive(1'b1, ADDU_A, 32'h200);
      hazard_stall = 1'b1;
      #1 chk("hz_ready", {31'b0, in_ready}, 0);
      tick;
      chk("hz_bub1", {31'b0, out_valid}, 0);
      tick;
      chk("hz_bub2", {31'b0, out_valid}, 0);
      hazard_stall = 1'b0;
      tick;
      chk("hz_issue", {31'b0, out_valid}, 1);
      chk("hz_pc", out_pc, 32'h200);
      in_valid = 1'b0;
      tick;
      chk("hz_once", {31'b0, out_valid}, 0);
      // EX backpressure holds the outputs
      drive(1'b1, 32'h30A4_8000, 32'h300);
      tick;
      chk("andi_imm", out_imm, 32'h8000);
      out_ready = 1'b0;
      drive(1'b1, 32'h24A4_FFFF, 32'h304);
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ready", {31'b0, in_ready}, 0);
         tick;
         chk("bp_valid", {31'b0, out_valid}, 1);
         chk("bp_pc", out_pc, 32'h300);
         chk("bp_imm", out_imm, 32'h8000);
      end
      out_ready = 1'b1;
      #1 chk("bp_rel", {31'b0, in_ready}, 1);
      tick;
      chk("addiu_pc", out_pc, 32'h304);
      chk("addiu_imm", out_imm, 32'hFFFF_FFFF);
      drive(1'b1, 32'h3C06_ABCD, 32'h308);
      tick;
      chk("lui_imm", out_imm, 32'hABCD_0000);
      in_valid = 1'b0;
      tick;
      // ex_flush while squashing
      drive(1'b1, 32'h1000_0002, 32'h400);
      tick;
      drive(1'b1, ADDU_A, 32'h404);
      tick;
      chk("fl_pre", {31'b0, out_valid}, 1);
      drive(1'b1, ADDU_A, 32'h408);
      ex_flush = 1'b1; hazard_stall = 1'b1;
      #1 chk("fl_ready", {31'b0, in_ready}, 1);
      chk("fl_br", {31'b0, br_taken}, 0);
      tick;
      ex_flush = 1'b0; hazard_stall = 1'b0;
      chk("fl_valid", {31'b0, out_valid}, 0);
      drive(1'b1, ADDU_A, 32'h500);
      tick;
      chk("fl_next", {31'b0, out_valid}, 1);
      chk("fl_pc", out_pc, 32'h500);
      // JAL, then an undefined opcode and a NOP at the target
      drive(1'b1, 32'h0C04_0000, 32'hBFC0_0010);
      #1 chk("jal_br", {31'b0, br_taken}, 1);
      chk("jal_tgt", br_target, 32'hB010_0000);
      tick;
      chk("jal_rd", {27'b0, out_rd}, 31);
      chk("jal_link", out_link, 32'hBFC0_0018);
      chk("jal_ctrl", {8'b0, out_ctrl}, 32'h8_0002);
      drive(1'b1, ADDU_A, 32'hBFC0_0014);
      tick;
      drive(1'b1, 32'hFC00_0000, 32'hB010_0000);
      #1 chk("ri_br", {31'b0, br_taken}, 0);
      tick;
      chk("ri_valid", {31'b0, out_valid}, 1);
      chk("ri_ctrl", {8'b0, out_ctrl}, 32'h2000);
      chk("ri_pc", out_pc, 32'hB010_0000);
      drive(1'b1, 32'h0, 32'hB010_0004);
      tick;
      chk("nop_valid", {31'b0, out_valid}, 1);
      chk("nop_ctrl", {8'b0, out_ctrl}, 0);
      in_valid = 1'b0;
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
